// File: rtl/sdram_arb_mc.sv
// sdram_arb_mc: SDRAM command-bus arbiter between an init sequencer, an
// auto-refresh engine and NCH access channels. Refresh wins over channels;
// a granted channel is asked to yield (ch_wait) when refresh is pending, and a
// sticky err flags a channel that takes WAIT_MAX cycles or more to yield.
//
// Ports:
//   sys_clk, sys_rst_n              clock, async active-low reset
//   init_done, init_cmd/ba/addr     init sequencer handshake and bus
//   ar_req, ar_end, ar_en           refresh request/done pulse/grant
//   ar_cmd/ba/addr                  refresh bus
//   ch_req, ch_end, ch_en, ch_wait  per-channel request/done/grant/yield
//   ch_cmd/ba/addr                  packed channel buses, channel k at slice k
//   cmdo/bao/addro                  SDRAM command bus (combinational mux)
//   grant_id, busy, err             last grant index, not-idle, yield timeout
//
// Build option: define SDRAM_ARB_RR_EN for round-robin channel selection;
// otherwise fixed priority with the lowest index winning.
module sdram_arb_mc #(
    parameter int unsigned NCH      = 2,
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned BA_W     = 2,
    parameter int unsigned CMD_W    = 4,
    parameter int unsigned WAIT_MAX = 64
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  init_done,
    input  logic [CMD_W-1:0]      init_cmd,
    input  logic [BA_W-1:0]       init_ba,
    input  logic [ADDR_W-1:0]     init_addr,
    input  logic                  ar_req,
    input  logic                  ar_end,
    output logic                  ar_en,
    input  logic [CMD_W-1:0]      ar_cmd,
    input  logic [BA_W-1:0]       ar_ba,
    input  logic [ADDR_W-1:0]     ar_addr,
    input  logic [NCH-1:0]        ch_req,
    input  logic [NCH-1:0]        ch_end,
    output logic [NCH-1:0]        ch_en,
    output logic [NCH-1:0]        ch_wait,
    input  logic [NCH*CMD_W-1:0]  ch_cmd,
    input  logic [NCH*BA_W-1:0]   ch_ba,
    input  logic [NCH*ADDR_W-1:0] ch_addr,
    output logic [CMD_W-1:0]      cmdo,
    output logic [BA_W-1:0]       bao,
    output logic [ADDR_W-1:0]     addro,
    output logic [1:0]            grant_id,
    output logic                  busy,
    output logic                  err
);

    localparam int unsigned TMR_W = $clog2(WAIT_MAX + 1);
    localparam logic [CMD_W-1:0] CMD_NOP = CMD_W'(4'b0111);

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_AREF, ST_ACCESS} state_t;

    state_t             state, state_d;
    logic               ar_en_d;
    logic [NCH-1:0]     ch_en_d, ch_wait_d;
    logic [1:0]         grant_d;
    logic [TMR_W-1:0]   timer;
    logic               sel_found;
    logic [1:0]         sel_idx;
    logic               end_g;

`ifdef SDRAM_ARB_RR_EN
    logic [1:0]         rr_ptr, rr_ptr_d;
`endif

    // ch_en is one-hot on the grant, so this picks ch_end of the granted channel only
    assign end_g = |(ch_end & ch_en);
    assign busy  = (state != ST_IDLE);

    // Channel selection: scan from the search start, first requester wins
    always_comb begin
        int k;
        sel_found = 1'b0;
        sel_idx   = 2'd0;
        k         = 0;
        for (int i = 0; i < int'(NCH); i++) begin
`ifdef SDRAM_ARB_RR_EN
            k = int'(rr_ptr) + i;
            if (k >= int'(NCH)) k = k - int'(NCH);
`else
            k = i;
`endif
            if (!sel_found && ((ch_req >> k) & NCH'(1)) != '0) begin
                sel_found = 1'b1;
                sel_idx   = 2'(k);
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d   = state;
        ar_en_d   = ar_en;
        ch_en_d   = ch_en;
        ch_wait_d = ch_wait;
        grant_d   = grant_id;
`ifdef SDRAM_ARB_RR_EN
        rr_ptr_d  = rr_ptr;
`endif
        case (state)
            ST_INIT: begin
                if (init_done) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (ar_req) begin
                    state_d = ST_AREF;
                    ar_en_d = 1'b1;
                end else if (sel_found) begin
                    state_d = ST_ACCESS;
                    ch_en_d = NCH'(1) << sel_idx;
                    grant_d = sel_idx;
`ifdef SDRAM_ARB_RR_EN
                    rr_ptr_d = (sel_idx == 2'(NCH - 1)) ? 2'd0 : sel_idx + 2'd1;
`endif
                end
            end
            ST_AREF: begin
                if (ar_end) begin
                    state_d = ST_IDLE;
                    ar_en_d = 1'b0;
                end
            end
            ST_ACCESS: begin
                if (end_g) begin
                    ch_en_d   = '0;
                    ch_wait_d = '0;
                    // Hand straight over to refresh without an IDLE cycle
                    if (ar_req) begin
                        state_d = ST_AREF;
                        ar_en_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (ar_req) begin
                    // Yield request latches until the channel finishes
                    ch_wait_d = ch_en;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= ST_INIT;
            ar_en    <= 1'b0;
            ch_en    <= '0;
            ch_wait  <= '0;
            grant_id <= 2'd0;
`ifdef SDRAM_ARB_RR_EN
            rr_ptr   <= 2'd0;
`endif
        end else begin
            state    <= state_d;
            ar_en    <= ar_en_d;
            ch_en    <= ch_en_d;
            ch_wait  <= ch_wait_d;
            grant_id <= grant_d;
`ifdef SDRAM_ARB_RR_EN
            rr_ptr   <= rr_ptr_d;
`endif
        end
    end

    // Yield timer: saturating count of ch_wait cycles, sticky err at WAIT_MAX
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            timer <= '0;
            err   <= 1'b0;
        end else if (ch_wait != '0) begin
            if (timer != TMR_W'(WAIT_MAX)) timer <= timer + TMR_W'(1);
            if (timer == TMR_W'(WAIT_MAX - 1)) err <= 1'b1;
        end else begin
            timer <= '0;
        end
    end

    // SDRAM bus mux by state
    always_comb begin
        cmdo  = CMD_NOP;
        bao   = '0;
        addro = '0;
        case (state)
            ST_INIT: begin
                cmdo  = init_cmd;
                bao   = init_ba;
                addro = init_addr;
            end
            ST_AREF: begin
                cmdo  = ar_cmd;
                bao   = ar_ba;
                addro = ar_addr;
            end
            ST_ACCESS: begin
                cmdo  = CMD_W'(ch_cmd >> (int'(grant_id) * int'(CMD_W)));
                bao   = BA_W'(ch_ba >> (int'(grant_id) * int'(BA_W)));
                addro = ADDR_W'(ch_addr >> (int'(grant_id) * int'(ADDR_W)));
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sdram_arb_mc.sv
// Directed self-checking bench for sdram_arb_mc (NCH=2, WAIT_MAX=8).
module tb_sdram_arb_mc;

    localparam int unsigned NCH = 2;

`ifdef SDRAM_ARB_RR_EN
    localparam logic [1:0] G2_ID = 2'd1;  // second channel grant in RR mode
    localparam logic [1:0] G4_ID = 2'd1;
`else
    localparam logic [1:0] G2_ID = 2'd0;
    localparam logic [1:0] G4_ID = 2'd0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              init_done;
    logic [3:0]        init_cmd;
    logic [1:0]        init_ba;
    logic [11:0]       init_addr;
    logic              ar_req, ar_end, ar_en;
    logic [3:0]        ar_cmd;
    logic [1:0]        ar_ba;
    logic [11:0]       ar_addr;
    logic [NCH-1:0]    ch_req, ch_end, ch_en, ch_wait;
    logic [NCH*4-1:0]  ch_cmd;
    logic [NCH*2-1:0]  ch_ba;
    logic [NCH*12-1:0] ch_addr;
    logic [3:0]        cmdo;
    logic [1:0]        bao;
    logic [11:0]       addro;
    logic [1:0]        grant_id;
    logic              busy, err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sdram_arb_mc #(.NCH(NCH), .ADDR_W(12), .BA_W(2), .CMD_W(4), .WAIT_MAX(8)) dut (
        .sys_clk(clk), .sys_rst_n(rst_n),
        .init_done(init_done), .init_cmd(init_cmd), .init_ba(init_ba), .init_addr(init_addr),
        .ar_req(ar_req), .ar_end(ar_end), .ar_en(ar_en),
        .ar_cmd(ar_cmd), .ar_ba(ar_ba), .ar_addr(ar_addr),
        .ch_req(ch_req), .ch_end(ch_end), .ch_en(ch_en), .ch_wait(ch_wait),
        .ch_cmd(ch_cmd), .ch_ba(ch_ba), .ch_addr(ch_addr),
        .cmdo(cmdo), .bao(bao), .addro(addro),
        .grant_id(grant_id), .busy(busy), .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ck();
        @(posedge clk);
        #1;
    endtask

    initial begin
        init_done = 0; ar_req = 0; ar_end = 0; ch_req = '0; ch_end = '0;
        init_cmd = 4'h1; init_ba = 2'd1; init_addr = 12'h0AA;
        ar_cmd = 4'h2; ar_ba = 2'd2; ar_addr = 12'h123;
        ch_cmd = {4'h5, 4'h4}; ch_ba = {2'd3, 2'd1}; ch_addr = {12'h222, 12'h111};
        rst_n = 1;
        #1 rst_n = 0;
        #2;
        chk("rst_cmdo", 32'(cmdo), 32'h1);
        chk("rst_addro", 32'(addro), 32'h0AA);
        chk("rst_ar_en", 32'(ar_en), 32'h0);
        chk("rst_ch_en", 32'(ch_en), 32'h0);
        chk("rst_grant", 32'(grant_id), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_busy", 32'(busy), 32'h1);
        #9 rst_n = 1;

        // Requests are ignored while initialising
        ar_req = 1; ch_req = 2'b11;
        ck();
        chk("init_ign_ar_en", 32'(ar_en), 32'h0);
        chk("init_ign_ch_en", 32'(ch_en), 32'h0);
        chk("init_ign_cmdo", 32'(cmdo), 32'h1);
        ar_req = 0; ch_req = 2'b00; init_done = 1;
        ck();
        init_done = 0;
        chk("idle_busy", 32'(busy), 32'h0);
        chk("idle_cmdo", 32'(cmdo), 32'h7);
        chk("idle_bao", 32'(bao), 32'h0);
        chk("idle_addro", 32'(addro), 32'h0);
        ck();
        chk("idle_stay_busy", 32'(busy), 32'h0);

        // Refresh beats channels when both arrive in IDLE
        ar_req = 1; ch_req = 2'b11;
        ck();
        ar_req = 0;
        chk("aref_ar_en", 32'(ar_en), 32'h1);
        chk("aref_ch_en", 32'(ch_en), 32'h0);
        chk("aref_cmdo", 32'(cmdo), 32'h2);
        chk("aref_bao", 32'(bao), 32'h2);
        chk("aref_addro", 32'(addro), 32'h123);
        ck();
        chk("aref_hold", 32'(ar_en), 32'h1);
        ar_end = 1;
        ck();
        ar_end = 0;
        chk("aref_end_ar_en", 32'(ar_en), 32'h0);
        chk("aref_end_busy", 32'(busy), 32'h0);

        // First channel grant: channel 0
        ck();
        chk("g1_ch_en", 32'(ch_en), 32'h1);
        chk("g1_grant", 32'(grant_id), 32'h0);
        chk("g1_cmdo", 32'(cmdo), 32'h4);
        chk("g1_bao", 32'(bao), 32'h1);
        chk("g1_addro", 32'(addro), 32'h111);
        // ch_end on the other channel and ar_end outside AREF are ignored
        ch_end = 2'b10; ar_end = 1;
        ck();
        ch_end = 2'b00; ar_end = 0;
        chk("ign_end_ch_en", 32'(ch_en), 32'h1);
        chk("ign_end_busy", 32'(busy), 32'h1);

        // Refresh pending during access: yield, then direct hand-over to AREF
        ar_req = 1;
        ck();
        chk("yield_wait", 32'(ch_wait), 32'h1);
        chk("yield_ch_en", 32'(ch_en), 32'h1);
        ch_end = 2'b01;
        ck();
        ch_end = 2'b00; ar_req = 0;
        chk("handover_ar_en", 32'(ar_en), 32'h1);
        chk("handover_ch_en", 32'(ch_en), 32'h0);
        chk("handover_wait", 32'(ch_wait), 32'h0);
        chk("handover_busy", 32'(busy), 32'h1);
        chk("handover_cmdo", 32'(cmdo), 32'h2);
        ar_end = 1;
        ck();
        ar_end = 0;
        chk("aref2_end", 32'(ar_en), 32'h0);

        // Second grant with both channels still requesting
        ck();
        chk("g2_ch_en", 32'(ch_en), 32'(2'b01 << G2_ID));
        chk("g2_grant", 32'(grant_id), 32'(G2_ID));
        chk("g2_cmdo", 32'(cmdo), (G2_ID == 2'd1) ? 32'h5 : 32'h4);
        ch_end = NCH'(2'b01 << G2_ID);
        ck();
        ch_end = 2'b00;
        chk("g2_end_ch_en", 32'(ch_en), 32'h0);
        chk("g2_end_busy", 32'(busy), 32'h0);
        chk("g2_end_grant_hold", 32'(grant_id), 32'(G2_ID));

        // Third grant: channel 0 in both modes
        ck();
        chk("g3_ch_en", 32'(ch_en), 32'h1);
        chk("g3_grant", 32'(grant_id), 32'h0);

        // Yield timeout: ch_wait held WAIT_MAX cycles without ch_end
        ar_req = 1;
        ck();
        ar_req = 0;
        chk("tmo_wait", 32'(ch_wait), 32'h1);
        for (int i = 0; i < 7; i++) ck();
        chk("tmo_err_before", 32'(err), 32'h0);
        ck();
        chk("tmo_err_set", 32'(err), 32'h1);
        chk("tmo_still_granted", 32'(ch_en), 32'h1);
        ch_end = 2'b01;
        ck();
        ch_end = 2'b00;
        chk("tmo_end_ch_en", 32'(ch_en), 32'h0);
        chk("tmo_end_wait", 32'(ch_wait), 32'h0);
        chk("tmo_err_sticky", 32'(err), 32'h1);

        // Fourth grant, then reset in the middle of the access
        ck();
        chk("g4_ch_en", 32'(ch_en), 32'(2'b01 << G4_ID));
        #2 rst_n = 0;
        #1;
        chk("midrst_ch_en", 32'(ch_en), 32'h0);
        chk("midrst_cmdo", 32'(cmdo), 32'h1);
        chk("midrst_err", 32'(err), 32'h0);
        chk("midrst_grant", 32'(grant_id), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h1);
        ch_req = 2'b00;
        #3 rst_n = 1;
        ck();
        ck();
        chk("post_rst_init_hold", 32'(cmdo), 32'h1);
        chk("post_rst_busy", 32'(busy), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sdram_arb_mc.md
SDRAM_ARB_MC -- requirements
Module: sdram_arb_mc

Interface
REQ-001 SHALL have these parameters, one per line (name, default, meaning):
- NCH, 2, number of access channels (1..4).
- ADDR_W, 12, SDRAM address width.
- BA_W, 2, bank address width.
- CMD_W, 4, command width.
- WAIT_MAX, 64, maximum cycles a channel may take to yield after ch_wait.

REQ-002 SHALL have these ports, one per line (name, direction, width, meaning); one clock, reset asynchronous active-low:
- sys_clk  in  1  clock.
- sys_rst_n  in  1  async active-low reset.
- init_done  in  1  initialisation complete.
- init_cmd/init_ba/init_addr  in  CMD_W/BA_W/ADDR_W  init-sequencer bus.
- ar_req  in  1  refresh request.
- ar_end  in  1  refresh done, 1-cycle pulse.
- ar_en  out  1  refresh grant.
- ar_cmd/ar_ba/ar_addr  in  CMD_W/BA_W/ADDR_W  refresh bus.
- ch_req  in  NCH  per-channel access request.
- ch_end  in  NCH  per-channel burst done, 1-cycle pulse.
- ch_en  out  NCH  one-hot channel grant.
- ch_wait  out  NCH  yield request to the granted channel.
- ch_cmd/ch_ba/ch_addr  in  NCH*CMD_W/NCH*BA_W/NCH*ADDR_W  channel buses, channel k at slice k.
- cmdo/bao/addro  out  CMD_W/BA_W/ADDR_W  SDRAM command bus.
- grant_id  out  2  index of the granted channel.
- busy  out  1  arbiter not in IDLE.
- err  out  1  sticky yield-timeout flag.

Function
REQ-003 SHALL implement state machine INIT, IDLE, AREF, ACCESS, with registered state.
REQ-004 INIT: SHALL mux the init bus to the outputs and go to IDLE on the cycle after init_done=1; ar_req and ch_req are ignored in INIT.
REQ-005 IDLE: if ar_req=1, SHALL go to AREF; otherwise, if any ch_req=1, SHALL go to ACCESS with the selected channel; otherwise stay.
REQ-006 Refresh SHALL win over channel requests when both are seen in IDLE in the same cycle.
REQ-007 The grant (ar_en or ch_en[k]) SHALL assert on the cycle after the IDLE decision and hold as a level until the matching end pulse.
REQ-008 AREF: on ar_end=1, SHALL deassert ar_en in the next cycle and return to IDLE.
REQ-009 ACCESS: if ar_req=1, SHALL assert ch_wait[grant] from the next cycle until ch_end[grant].
REQ-010 On ch_end[grant], SHALL deassert ch_en/ch_wait in the next cycle and go to AREF if ar_req=1, else to IDLE.
REQ-011 When ch_end and ar_req arrive in the same cycle, SHALL go directly to AREF with no IDLE cycle.
REQ-012 Outputs cmdo/bao/addro SHALL be combinationally muxed by state:
- INIT: init bus.
- AREF: ar bus.
- ACCESS: granted channel's bus.
- IDLE: cmdo=4'b0111 (NOP), bao=0, addro=0.
REQ-013 ch_end on a non-granted channel, and ar_end outside AREF, SHALL be ignored.
REQ-014 A channel deasserting ch_req before it is granted SHALL not be granted.
REQ-015 Yield timer:
- SHALL count cycles while ch_wait is asserted.
- If the count reaches WAIT_MAX without ch_end, SHALL set err=1.
- err is sticky until reset; arbitration continues unchanged.
- The counter clears whenever ch_wait deasserts.
REQ-016 busy SHALL be 1 in every state except IDLE.
REQ-017 grant_id SHALL hold the last granted index in all states.

Reset
REQ-018 Asserting sys_rst_n=0 at any time SHALL asynchronously force:
- state=INIT.
- ar_en=0, ch_en=0, ch_wait=0.
- grant_id=0, err=0, timer=0.
- round-robin pointer=0.
REQ-019 Reset in the middle of an access or refresh SHALL abort it without issuing further commands, and a new init_done is required after reset.

Configuration
REQ-020 Macro SDRAM_ARB_RR_EN:
- Defined: channel selection is round-robin, starting from the index after the last grant (wrapping NCH-1 to 0).
- Undefined: channel selection is fixed priority, with the lowest index winning.

Verification
REQ-021 The bench SHALL cover:
- init_done pulse, then ar_req=1 with ch_req=2'b11 in the same cycle -> ar_en=1 next cycle, ch_en=0; cmdo follows ar_cmd.
- Channel 0 granted, then ar_req=1 -> ch_wait[0]=1 next cycle; ch_end[0] -> ar_en=1 one cycle later with no IDLE cycle; busy stays 1.
- SDRAM_ARB_RR_EN defined, ch_req=2'b11 held -> grants alternate 0,1,0 (grant_id 0,1,0); undefined -> always channel 0.
- WAIT_MAX=8, ch_wait held 8 cycles with no ch_end -> err=1 and stays 1 after the later ch_end.
- sys_rst_n=0 mid-ACCESS -> ch_en=0, cmdo=init_cmd immediately, err=0.
- IDLE with no requests -> cmdo=4'b0111, bao=0, addro=0, busy=0.
